addarray_pipe: RTL and testbench

- Parametrised successor to the blitter's fixed four-lane 16-bit adder array.
- LANES independent adders of WIDTH bits each, with a 3-bit mode selecting modulo, unsigned-saturating, signed-saturating, lane-chained or intensity arithmetic.
- Two-stage pipeline with valid/ready flow control on both sides, plus sticky per-lane saturation flags for the blitter status path.

---
 rtl/addarray_pipe_if.sv | 40 ++++
 rtl/addarray_pipe.sv | 189 ++++++++++++++++++
 tb/tb_addarray_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addarray_pipe_if.sv
// ---------------------------------------------------------------------------
// addarray_pipe_if
//   Bundles the beat/result handshake and the status signals of the
//   addarray_pipe lane adder.
//
//   master : the upstream/downstream agent (drives beats, accepts results)
//   slave  : the adder block itself
//
//   in_valid/in_ready        : input beat handshake
//   mode, adda, addb         : beat payload, lane i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready      : result handshake
//   addq                     : result payload, same packing as the operands
//   sat_flags                : sticky per-lane saturation/overflow flags
//   sat_clr                  : synchronous clear of sat_flags
// ---------------------------------------------------------------------------
interface addarray_pipe_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             mode;
    logic [LANES*WIDTH-1:0] adda;
    logic [LANES*WIDTH-1:0] addb;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] addq;
    logic [LANES-1:0]       sat_flags;
    logic                   sat_clr;

    modport master (
        output in_valid, mode, adda, addb, out_ready, sat_clr,
        input  in_ready, out_valid, addq, sat_flags
    );

    modport slave (
        input  in_valid, mode, adda, addb, out_ready, sat_clr,
        output in_ready, out_valid, addq, sat_flags
    );
endinterface

// File: rtl/addarray_pipe.sv
// ---------------------------------------------------------------------------
// addarray_pipe
//   LANES independent WIDTH-bit adders with a per-beat arithmetic mode,
//   behind a two-stage valid/ready pipeline.
//
//   Modes (per lane, a = A lane, b = B lane):
//     000 modulo             q = a+b mod 2^WIDTH
//     001 unsigned saturate  carry-out -> all ones, sat
//     010 signed saturate    overflow  -> max/min by sign of a, sat
//     011 chained            one LANES*WIDTH-bit add, lane 0 is LSB;
//                            sat of the top lane is the final carry-out
//     100 intensity          low byte: unsigned a + signed b, clamped 0..255;
//                            upper bits pass through from a
//     101..111 treated as 000
//
//   Ports:
//     sys_clk  : clock, all state on the rising edge
//     reset_n  : asynchronous active-low reset
//     bus      : addarray_pipe_if slave (handshakes, operands, result,
//                sticky sat_flags and their clear)
//
//   Stage 1 holds the captured beat; stage 2 holds the computed result.
//   sat_flags collect the sat bits of every result entering stage 2.
// ---------------------------------------------------------------------------

// Single lane: all mode arithmetic for one WIDTH-bit slice. The carry input
// is only honoured in chained mode so the lanes stay independent otherwise.
module addarray_lane #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    input  logic             cin,
    output logic [WIDTH-1:0] q,
    output logic             sat,
    output logic             cout
);
    logic             chain;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [9:0]       isum;

    always_comb begin
        chain = (mode == 3'b011);
        sum   = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(chain & cin);
        cout  = sum[WIDTH];
        // Signed overflow: operands agree in sign but the result does not.
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        // 10-bit signed intermediate covers -128..382 without wrapping.
        isum  = {2'b00, a[7:0]} + {{2{b[7]}}, b[7:0]};

        q   = sum[WIDTH-1:0];
        sat = 1'b0;
        case (mode)
            3'b001: begin
                if (sum[WIDTH]) begin
                    q   = '1;
                    sat = 1'b1;
                end
            end
            3'b010: begin
                if (ovf) begin
                    q   = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
                    sat = 1'b1;
                end
            end
            3'b100: begin
                q = a;
                if (isum[9]) begin
                    q[7:0] = 8'h00;
                    sat    = 1'b1;
                end else if (isum[8]) begin
                    q[7:0] = 8'hFF;
                    sat    = 1'b1;
                end else begin
                    q[7:0] = isum[7:0];
                end
            end
            // Chained sat is produced at the top from the last lane's carry.
            default: ;
        endcase
    end
endmodule

module addarray_pipe #(
    parameter int LANES = 4,
    parameter int WIDTH = 16
) (
    input  logic            sys_clk,
    input  logic            reset_n,
    addarray_pipe_if.slave  bus
);
    typedef struct packed {
        logic [2:0]                  mode;
        logic [LANES-1:0][WIDTH-1:0] a;
        logic [LANES-1:0][WIDTH-1:0] b;
    } req_t;

    req_t                        s1_req;
    logic                        s1_valid;
    logic                        s2_valid;
    logic [LANES-1:0][WIDTH-1:0] addq_r;
    logic [LANES-1:0]            sat_r;

    logic                        s1_adv;
    logic                        s2_adv;
    logic                        s2_load;

    logic [LANES-1:0][WIDTH-1:0] q_comb;
    logic [LANES-1:0]            lane_sat;
    logic [LANES-1:0]            sat_comb;

    // Each stage advances when it is empty or the stage after it drains.
    assign s2_adv  = !s2_valid || bus.out_ready;
    assign s1_adv  = !s1_valid || s2_adv;
    assign s2_load = s2_adv && s1_valid;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.addq      = addq_r;
    assign bus.sat_flags = sat_r;

    // Lane array; the carry ripples through per-lane scalars.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic cin;
        logic cout;

        if (i == 0) begin : g_lsb
            assign cin = 1'b0;
        end else begin : g_mid
            assign cin = g_lane[i-1].cout;
        end

        addarray_lane #(.WIDTH(WIDTH)) u_lane (
            .a    (s1_req.a[i]),
            .b    (s1_req.b[i]),
            .mode (s1_req.mode),
            .cin  (cin),
            .q    (q_comb[i]),
            .sat  (lane_sat[i]),
            .cout (cout)
        );
    end

    always_comb begin
        sat_comb = lane_sat;
        sat_comb[LANES-1] = lane_sat[LANES-1] |
                            ((s1_req.mode == 3'b011) & g_lane[LANES-1].cout);
    end

    // Stage 1: capture the beat.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_req.mode <= bus.mode;
                s1_req.a    <= bus.adda;
                s1_req.b    <= bus.addb;
            end
        end
    end

    // Stage 2: register the result; held while the consumer stalls.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            addq_r   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                addq_r <= q_comb;
            end
        end
    end

    // Sticky flags: a set arriving with a clear wins.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_r <= '0;
        end else begin
            sat_r <= (bus.sat_clr ? '0 : sat_r) | (s2_load ? sat_comb : '0);
        end
    end
endmodule

// File: tb/tb_addarray_pipe.sv
// ---------------------------------------------------------------------------
// tb_addarray_pipe
//   Scoreboard bench for addarray_pipe (LANES=4, WIDTH=16). The driver pushes
//   the expected result of every accepted beat; a monitor pops and compares
//   whenever a result transfers, and checks that a stalled output holds.
// ---------------------------------------------------------------------------
module tb_addarray_pipe;
    localparam int LANES = 4;
    localparam int WIDTH = 16;
    localparam int DW    = LANES * WIDTH;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;

    addarray_pipe_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

    addarray_pipe #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [DW-1:0]    q;
        logic [LANES-1:0] sat;
        bit               clr_before;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   clr_pending = 1'b0;
    int   accepted = 0;
    bit   bp_rand  = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on each lane.
    function automatic exp_t model(input logic [2:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t        e;
        logic [DW:0] full;
        longint      ua, ub, sa, sb, s, lo, blo;
        longint      half, modv;
        half = longint'(1) << (WIDTH-1);
        modv = longint'(1) << WIDTH;
        e.q = '0;
        e.sat = '0;
        e.clr_before = 1'b0;
        if (m == 3'b011) begin
            full = {1'b0, a} + {1'b0, b};
            e.q = full[DW-1:0];
            e.sat[LANES-1] = full[DW];
            return e;
        end
        for (int i = 0; i < LANES; i++) begin
            ua = longint'(a[i*WIDTH +: WIDTH]);
            ub = longint'(b[i*WIDTH +: WIDTH]);
            case (m)
                3'b001: begin
                    s = ua + ub;
                    if (s > modv - 1) begin s = modv - 1; e.sat[i] = 1'b1; end
                end
                3'b010: begin
                    sa = (ua >= half) ? ua - modv : ua;
                    sb = (ub >= half) ? ub - modv : ub;
                    s  = sa + sb;
                    if (s > half - 1) begin s = half - 1; e.sat[i] = 1'b1; end
                    else if (s < -half) begin s = -half; e.sat[i] = 1'b1; end
                end
                3'b100: begin
                    blo = ub % 256;
                    if (blo >= 128) blo = blo - 256;
                    lo = (ua % 256) + blo;
                    if (lo < 0) begin lo = 0; e.sat[i] = 1'b1; end
                    else if (lo > 255) begin lo = 255; e.sat[i] = 1'b1; end
                    s = (ua - (ua % 256)) + lo;
                end
                default: s = (ua + ub) % modv;
            endcase
            e.q[i*WIDTH +: WIDTH] = s[WIDTH-1:0];
        end
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_lane();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(WIDTH-1){1'b0}}};
            3: return {1'b0, {(WIDTH-1){1'b1}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    function automatic logic [DW-1:0] rnd_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = rnd_lane();
        return v;
    endfunction

    // Issue one beat; starts and ends at posedge+1. Expected value is either
    // the given constant or the model's answer.
    task automatic send(input logic [2:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input bit use_exp, input logic [DW-1:0] eq, input logic [LANES-1:0] es);
        exp_t e;
        bit   rdy;
        int   t;
        if (use_exp) begin
            e.q = eq;
            e.sat = es;
        end else begin
            e = model(m, a, b);
        end
        e.clr_before = clr_pending;
        bus.in_valid = 1'b1;
        bus.mode = m;
        bus.adda = a;
        bus.addb = b;
        t = 0;
        rdy = 1'b0;
        forever begin
            @(negedge sys_clk);
            rdy = bus.in_ready;
            @(posedge sys_clk);
            if (rdy) break;
            t++;
            if (t > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: in_ready low for %0d cycles", t);
                break;
            end
        end
        if (rdy) begin
            exp_q.push_back(e);
            clr_pending = 1'b0;
            accepted++;
        end
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic send_rnd();
        logic [2:0] m;
        m = 3'($urandom_range(0, 7));
        send(m, rnd_vec(), rnd_vec(), 1'b0, '0, '0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && t < 500) begin
            @(posedge sys_clk);
            t++;
        end
        if (t >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_flags();
        bus.sat_clr = 1'b1;
        @(posedge sys_clk);
        #1 bus.sat_clr = 1'b0;
        clr_pending = 1'b1;
        @(negedge sys_clk);
        chk("sat_clr", bus.sat_flags, '0);
        @(posedge sys_clk);
        #1;
    endtask

    // Monitor: compare every transferred result and check stall stability.
    initial begin : monitor
        logic [LANES-1:0] acc;
        bit               prev_stall;
        logic [DW-1:0]    prev_q;
        exp_t             e;
        acc = '0;
        prev_stall = 1'b0;
        prev_q = '0;
        forever begin
            @(negedge sys_clk);
            if (!reset_n) begin
                acc = '0;
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1'b1);
                chk("stall_addq", bus.addq, prev_q);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: addq %h with empty scoreboard", bus.addq);
                end else begin
                    e = exp_q.pop_front();
                    if (e.clr_before) acc = '0;
                    acc |= e.sat;
                    chk("addq", bus.addq, e.q);
                    chk("sat_flags", bus.sat_flags, acc);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_q = bus.addq;
        end
    end

    // Random back-pressure source.
    initial begin : bp_gen
        forever begin
            @(posedge sys_clk);
            #1;
            if (bp_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        bus.in_valid = 1'b0;
        bus.mode = '0;
        bus.adda = '0;
        bus.addb = '0;
        bus.out_ready = 1'b1;
        bus.sat_clr = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_addq", bus.addq, '0);
        chk("rst_sat_flags", bus.sat_flags, '0);
        #2 reset_n = 1'b1;
        @(negedge sys_clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge sys_clk);
        #1;

        // Modulo
        send(3'b000, 64'h0000_0000_1234_FFFF, 64'h0000_0000_1111_0002, 1'b1,
             64'h0000_0000_2345_0001, 4'b0000);
        // Reserved modes behave as modulo
        send(3'b101, 64'h0001_0000_0000_FFFF, 64'hFFFF_0000_0000_0001, 1'b1,
             64'h0000_0000_0000_0000, 4'b0000);
        send(3'b111, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1,
             64'h0000_0000_0000_0001, 4'b0000);
        drain();

        // Unsigned saturate; flag must stay until cleared
        send(3'b001, 64'h0000_F000_0000_0000, 64'h0000_2000_0000_0000, 1'b1,
             64'h0000_FFFF_0000_0000, 4'b0100);
        drain();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("sat_hold", bus.sat_flags, 4'b0100);
        @(posedge sys_clk);
        #1;
        clear_flags();

        // Signed saturate
        send(3'b010, 64'h0000_0000_8000_7FFF, 64'h0000_0000_FFFF_0001, 1'b1,
             64'h0000_0000_8000_7FFF, 4'b0011);
        drain();
        clear_flags();

        // Chained
        send(3'b011, 64'h0000_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1,
             64'h0001_0000_0000_0000, 4'b0000);
        send(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1,
             64'h0000_0000_0000_0000, 4'b1000);
        // Intensity: clamp low, in range, clamp high, max positive b
        send(3'b100, 64'h1200_00F0_AB80_AB10, 64'hFF7F_0020_0020_00E0, 1'b1,
             64'h127F_00FF_ABA0_AB00, 4'b0101);
        drain();
        clear_flags();

        // Back-pressure: 5 beats against a stalled consumer
        bus.out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) send_rnd();
            end
            begin
                repeat (4) @(posedge sys_clk);
                @(negedge sys_clk);
                chk("bp_accepted", 64'(accepted), 64'd2);
                chk("bp_in_ready", bus.in_ready, 1'b0);
                chk("bp_out_valid", bus.out_valid, 1'b1);
                @(posedge sys_clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random back-pressure and idle gaps
        bp_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_rnd();
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge sys_clk);
                #1;
            end
        end
        bp_rand = 1'b0;
        @(posedge sys_clk);
        #2 bus.out_ready = 1'b1;
        drain();

        // Reset mid-stream: in-flight beats vanish immediately
        for (int i = 0; i < 3; i++) send_rnd();
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_addq", bus.addq, '0);
        chk("midrst_sat_flags", bus.sat_flags, '0);
        exp_q.delete();
        clr_pending = 1'b0;
        repeat (2) @(posedge sys_clk);
        #3 reset_n = 1'b1;
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < 6; i++) send_rnd();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
